// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-rate divider, x/y counters, sync/blanking decode and line/frame strobes.
// Define FRAME_COUNTER_EN to add the 8-bit frame_cnt output and its register.
module video_timing_gen #(
  parameter int   H_ACTIVE = 128,
  parameter int   H_FP     = 2,
  parameter int   H_SYNC   = 2,
  parameter int   H_BP     = 2,
  parameter int   V_ACTIVE = 64,
  parameter int   V_FP     = 2,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 2,
  parameter int   CLK_DIV  = 2,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   X_BITS   = 9,
  parameter int   Y_BITS   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic              p_tick,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              line_start,
`ifdef FRAME_COUNTER_EN
  output logic              frame_start,
  output logic [7:0]        frame_cnt
`else
  output logic              frame_start
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_BITS-1:0] X_LAST   = X_BITS'(H_TOTAL - 1);
  localparam logic [Y_BITS-1:0] Y_LAST   = Y_BITS'(V_TOTAL - 1);
  localparam logic [X_BITS-1:0] X_ACT    = X_BITS'(H_ACTIVE);
  localparam logic [Y_BITS-1:0] Y_ACT    = Y_BITS'(V_ACTIVE);
  localparam logic [X_BITS-1:0] HS_FIRST = X_BITS'(H_ACTIVE + H_FP);
  localparam logic [X_BITS-1:0] HS_LAST  = X_BITS'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_BITS-1:0] VS_FIRST = Y_BITS'(V_ACTIVE + V_FP);
  localparam logic [Y_BITS-1:0] VS_LAST  = Y_BITS'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic             x_wrap;
  logic             y_wrap;

  // Strobe is gated by reset so nothing pulses while the block is held, even with CLK_DIV=1.
  assign p_tick = en && !reset && (div == DIV_LAST);
  assign x_wrap = (x == X_LAST);
  assign y_wrap = (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (p_tick) begin
      if (x_wrap) begin
        x <= '0;
        y <= y_wrap ? '0 : y + Y_BITS'(1);
      end else begin
        x <= x + X_BITS'(1);
      end
    end
  end

  // Pure decode of the registered counters: no added latency.
  always_comb begin
    hsync       = ((x >= HS_FIRST) && (x <= HS_LAST)) ? HS_POL : ~HS_POL;
    vsync       = ((y >= VS_FIRST) && (y <= VS_LAST)) ? VS_POL : ~VS_POL;
    video_on    = (x < X_ACT) && (y < Y_ACT);
    line_start  = p_tick && (x == '0);
    frame_start = p_tick && (x == '0) && (y == '0);
  end

`ifdef FRAME_COUNTER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (p_tick && x_wrap && y_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: expected timing derived from the count of enabled clocks since reset.
module tb_video_timing_gen;
  localparam int HA = 128, HF = 2, HS = 2, HB = 2;
  localparam int VA = 64,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLKS = HT * VT * 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, p_tick, hsync, vsync, video_on, line_start, frame_start;
  logic [8:0] x;
  logic [7:0] y;
  logic reset2, en2, p_tick2, hsync2, vsync2, video_on2, line_start2, frame_start2;
  logic [8:0] x2;
  logic [7:0] y2;

  int tests = 0;
  int fails = 0;
  int n  = 0;
  int n2 = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) n <= 0; else if (en) n <= n + 1;
    if (reset2) n2 <= 0; else if (en2) n2 <= n2 + 1;
  end

`ifdef FRAME_COUNTER_EN
  logic [7:0] frame_cnt, frame_cnt2, frame_cnt3;
  logic reset3, en3, p_tick3, hsync3, vsync3, video_on3, line_start3, frame_start3;
  logic [2:0] x3, y3;
  int n3 = 0;
  always @(posedge clk) if (reset3) n3 <= 0; else if (en3) n3 <= n3 + 1;

  video_timing_gen dut (.clk(clk), .reset(reset), .en(en), .p_tick(p_tick), .hsync(hsync),
    .vsync(vsync), .video_on(video_on), .x(x), .y(y), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt));
  video_timing_gen #(.CLK_DIV(1), .HS_POL(1'b0)) dut2 (.clk(clk), .reset(reset2), .en(en2),
    .p_tick(p_tick2), .hsync(hsync2), .vsync(vsync2), .video_on(video_on2), .x(x2), .y(y2),
    .line_start(line_start2), .frame_start(frame_start2), .frame_cnt(frame_cnt2));
  video_timing_gen #(.H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .CLK_DIV(1), .X_BITS(3), .Y_BITS(3)) dut3 (.clk(clk), .reset(reset3),
    .en(en3), .p_tick(p_tick3), .hsync(hsync3), .vsync(vsync3), .video_on(video_on3), .x(x3),
    .y(y3), .line_start(line_start3), .frame_start(frame_start3), .frame_cnt(frame_cnt3));
`else
  video_timing_gen dut (.clk(clk), .reset(reset), .en(en), .p_tick(p_tick), .hsync(hsync),
    .vsync(vsync), .video_on(video_on), .x(x), .y(y), .line_start(line_start),
    .frame_start(frame_start));
  video_timing_gen #(.CLK_DIV(1), .HS_POL(1'b0)) dut2 (.clk(clk), .reset(reset2), .en(en2),
    .p_tick(p_tick2), .hsync(hsync2), .vsync(vsync2), .video_on(video_on2), .x(x2), .y(y2),
    .line_start(line_start2), .frame_start(frame_start2));
`endif

  // Reference model: pixel index = enabled clocks / divider, raster position from that index.
  function automatic int m_x(int cnt, int div, int ht);
    return (cnt / div) % ht;
  endfunction
  function automatic int m_y(int cnt, int div, int ht, int vt);
    return (cnt / div / ht) % vt;
  endfunction
  function automatic logic m_tick(int cnt, int div, logic e, logic r);
    return e && !r && ((cnt % div) == div - 1);
  endfunction
  function automatic logic m_sync(int pos, int act, int fp, int sw, logic pol);
    return (pos >= act + fp && pos < act + fp + sw) ? pol : ~pol;
  endfunction

  // Advance one clock, then apply the enable for the coming cycle and let decode settle.
  task automatic cycle(input logic e);
    @(posedge clk);
    #1;
    en = e;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    tests++; if (p_tick !== 1'b0) begin fails++; $display("FAIL reset_p_tick got %b want 0", p_tick); end
    tests++; if (x !== 9'd0) begin fails++; $display("FAIL reset_x got %0d want 0", x); end
    tests++; if (y !== 8'd0) begin fails++; $display("FAIL reset_y got %0d want 0", y); end
    tests++; if (hsync !== 1'b0) begin fails++; $display("FAIL reset_hsync got %b want 0", hsync); end
    tests++; if (vsync !== 1'b0) begin fails++; $display("FAIL reset_vsync got %b want 0", vsync); end
    tests++; if (video_on !== 1'b1) begin fails++; $display("FAIL reset_video_on got %b want 1", video_on); end
    tests++; if (line_start !== 1'b0) begin fails++; $display("FAIL reset_line_start got %b want 0", line_start); end
    tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
  endtask

  task automatic test_startup();
    int xs[$];
    reset = 1'b0;
    #1;
    for (int k = 0; k < 12; k++) begin
      tests++;
      if (p_tick !== m_tick(n, 2, en, reset)) begin
        fails++; $display("FAIL start_p_tick clk %0d got %b want %b", k, p_tick, m_tick(n, 2, en, reset));
      end
      tests++;
      if (int'(x) !== m_x(n, 2, HT)) begin
        fails++; $display("FAIL start_x clk %0d got %0d want %0d", k, x, m_x(n, 2, HT));
      end
      if (p_tick === 1'b1) xs.push_back(int'(x));
      cycle(1'b1);
    end
    tests++;
    if (xs.size() < 3 || xs[0] != 0 || xs[1] != 1 || xs[2] != 2) begin
      fails++; $display("FAIL start_x_steps got %p want 0,1,2", xs);
    end
  endtask

  task automatic test_line();
    int ls = 0;
    do_reset();
    for (int k = 0; k < 2 * HT * 2 + 20; k++) begin
      int ex, ey;
      logic et;
      ex = m_x(n, 2, HT); ey = m_y(n, 2, HT, VT); et = m_tick(n, 2, en, reset);
      tests++;
      if (int'(x) !== ex || int'(y) !== ey) begin
        fails++; $display("FAIL line_xy got %0d,%0d want %0d,%0d", x, y, ex, ey); break;
      end
      tests++;
      if (hsync !== m_sync(ex, HA, HF, HS, 1'b1) || video_on !== (ex < HA && ey < VA)) begin
        fails++; $display("FAIL line_decode x %0d got hs %b von %b", ex, hsync, video_on); break;
      end
      tests++;
      if (line_start !== (et && ex == 0)) begin
        fails++; $display("FAIL line_start x %0d got %b want %b", ex, line_start, et && ex == 0); break;
      end
      if (line_start === 1'b1) ls++;
      cycle(1'b1);
    end
    tests++;
    if (ls != 3) begin fails++; $display("FAIL line_start_count got %0d want 3", ls); end
  endtask

  task automatic test_random_en();
    for (int k = 0; k < 3000; k++) begin
      int ex, ey;
      logic et;
      cycle($urandom_range(0, 3) != 0);
      ex = m_x(n, 2, HT); ey = m_y(n, 2, HT, VT); et = m_tick(n, 2, en, reset);
      tests++;
      if (int'(x) !== ex || int'(y) !== ey || p_tick !== et) begin
        fails++; $display("FAIL rand_state got x%0d y%0d t%b want x%0d y%0d t%b", x, y, p_tick, ex, ey, et);
        break;
      end
      tests++;
      if (line_start !== (et && ex == 0) || frame_start !== (et && ex == 0 && ey == 0)) begin
        fails++; $display("FAIL rand_strobes got ls%b fs%b at x%0d y%0d", line_start, frame_start, ex, ey);
        break;
      end
    end
  endtask

  task automatic test_en_hold();
    int guard = 0;
    do_reset();
    while (m_x(n, 2, HT) != 50 && guard < 500) begin cycle(1'b1); guard++; end
    tests++;
    if (int'(x) !== 50) begin fails++; $display("FAIL hold_reach_x got %0d want 50", x); end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0);
      tests++;
      if (x !== 9'd50 || p_tick !== 1'b0) begin
        fails++; $display("FAIL hold_x_tick clk %0d got x%0d t%b want x50 t0", k, x, p_tick);
      end
    end
    cycle(1'b1);
    guard = 0;
    while (p_tick !== 1'b1 && guard < 4) begin cycle(1'b1); guard++; end
    tests++;
    if (p_tick !== 1'b1) begin fails++; $display("FAIL hold_resume_tick got %b want 1", p_tick); end
    cycle(1'b1);
    tests++;
    if (x !== 9'd51) begin fails++; $display("FAIL hold_resume_x got %0d want 51", x); end
  endtask

  task automatic test_frames();
    int fs = 0;
    int last = -1;
    do_reset();
    for (int k = 0; k < 2 * FRAME_CLKS + 200; k++) begin
      int ey;
      ey = m_y(n, 2, HT, VT);
      if (vsync !== m_sync(ey, VA, VF, VS, 1'b1)) begin
        tests++; fails++; $display("FAIL frame_vsync y %0d got %b", ey, vsync); break;
      end
      if (frame_start === 1'b1) begin
        fs++;
        if (last >= 0) begin
          tests++;
          if (cyc - last != FRAME_CLKS) begin
            fails++; $display("FAIL frame_period got %0d want %0d", cyc - last, FRAME_CLKS);
          end
        end
        last = cyc;
      end
      cycle(1'b1);
    end
    tests++;
    if (fs != 3) begin fails++; $display("FAIL frame_count got %0d want 3", fs); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do_reset();
    while (!(m_x(n, 2, HT) == 50 && m_y(n, 2, HT, VT) == 30) && guard < 20000) begin
      cycle(1'b1); guard++;
    end
    tests++;
    if (x !== 9'd50 || y !== 8'd30) begin fails++; $display("FAIL mid_reach got %0d,%0d want 50,30", x, y); end
    reset = 1'b1;
    cycle(1'b1);
    tests++;
    if (x !== 9'd0 || y !== 8'd0 || p_tick !== 1'b0) begin
      fails++; $display("FAIL mid_reset got x%0d y%0d t%b want 0,0,0", x, y, p_tick);
    end
    reset = 1'b0;
    cycle(1'b1);
    tests++;
    if (p_tick !== 1'b1 || x !== 9'd0) begin
      fails++; $display("FAIL mid_restart got t%b x%0d want t1 x0", p_tick, x);
    end
  endtask

  task automatic test_clkdiv1();
    int last = -1;
    int lines = 0;
    reset2 = 1'b1; en2 = 1'b1;
    cycle(en);
    reset2 = 1'b0;
    cycle(en);
    for (int k = 0; k < 3 * HT + 5; k++) begin
      int ex;
      ex = m_x(n2, 1, HT);
      tests++;
      if (p_tick2 !== 1'b1 || int'(x2) !== ex) begin
        fails++; $display("FAIL div1_tick_x got t%b x%0d want t1 x%0d", p_tick2, x2, ex); break;
      end
      tests++;
      if (hsync2 !== ((ex == 130 || ex == 131) ? 1'b0 : 1'b1)) begin
        fails++; $display("FAIL div1_hsync x %0d got %b", ex, hsync2); break;
      end
      if (line_start2 === 1'b1) begin
        if (last >= 0) begin
          tests++;
          if (cyc - last != HT) begin fails++; $display("FAIL div1_line_period got %0d want %0d", cyc - last, HT); end
        end
        last = cyc; lines++;
      end
      cycle(en);
    end
    tests++;
    if (lines != 3) begin fails++; $display("FAIL div1_lines got %0d want 3", lines); end
  endtask

`ifdef FRAME_COUNTER_EN
  task automatic test_frame_cnt();
    reset3 = 1'b1; en3 = 1'b1;
    cycle(en);
    reset3 = 1'b0;
    #1;
    while (n3 < 3 * 25) cycle(en);
    tests++;
    if (frame_cnt3 !== 8'd3) begin fails++; $display("FAIL fcnt_three got %0d want 3", frame_cnt3); end
    while (n3 < 255 * 25) cycle(en);
    tests++;
    if (frame_cnt3 !== 8'd255) begin fails++; $display("FAIL fcnt_255 got %0d want 255", frame_cnt3); end
    while (n3 < 256 * 25) cycle(en);
    tests++;
    if (frame_cnt3 !== 8'((n3 / 25) % 256)) begin
      fails++; $display("FAIL fcnt_wrap got %0d want %0d", frame_cnt3, (n3 / 25) % 256);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; en = 1'b0; reset2 = 1'b1; en2 = 1'b0;
`ifdef FRAME_COUNTER_EN
    reset3 = 1'b1; en3 = 1'b0;
`endif
    test_reset();
    test_startup();
    test_line();
    test_random_en();
    test_en_hold();
    test_frames();
    test_reset_mid();
    test_clkdiv1();
`ifdef FRAME_COUNTER_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
